// File: rtl/draw_scheduler_if.sv
// Draw scheduler bus bundle.
// Groups the frame/scroll controls, both engine handshakes and pixel buses, and the arbitrated
// VGA write port into one interface.
//   slave  : the scheduler's view (controls and engine outputs in, enables/VGA/status out)
//   master : the environment's view (the mirror image of slave)
interface draw_scheduler_if #(
    parameter int unsigned COLOR_DEPTH = 9,
    parameter int unsigned OFFSET_W    = 11
);
    logic                   frame_tick;
    logic                   scroll_left;
    logic                   scroll_right;
    logic                   spr_phase_en;
    logic                   bg_done;
    logic                   spr_done;
    logic [7:0]             bg_x;
    logic [7:0]             spr_x;
    logic [6:0]             bg_y;
    logic [6:0]             spr_y;
    logic [COLOR_DEPTH-1:0] bg_color;
    logic [COLOR_DEPTH-1:0] spr_color;
    logic                   bg_plot;
    logic                   spr_plot;
    logic                   bg_enable;
    logic                   spr_enable;
    logic [OFFSET_W-1:0]    x_offset;
    logic [7:0]             vga_x;
    logic [6:0]             vga_y;
    logic [COLOR_DEPTH-1:0] vga_color;
    logic                   vga_plot;
    logic                   busy;
    logic [7:0]             overrun_count;

    modport slave (
        input  frame_tick, scroll_left, scroll_right, spr_phase_en, bg_done, spr_done,
        input  bg_x, spr_x, bg_y, spr_y, bg_color, spr_color, bg_plot, spr_plot,
        output bg_enable, spr_enable, x_offset, vga_x, vga_y, vga_color, vga_plot, busy,
        output overrun_count
    );

    modport master (
        output frame_tick, scroll_left, scroll_right, spr_phase_en, bg_done, spr_done,
        output bg_x, spr_x, bg_y, spr_y, bg_color, spr_color, bg_plot, spr_plot,
        input  bg_enable, spr_enable, x_offset, vga_x, vga_y, vga_color, vga_plot, busy,
        input  overrun_count
    );
endinterface

// File: rtl/draw_scheduler.sv
// Draw scheduler: sequences one frame redraw per frame_tick. It runs the background engine,
// then optionally the sprite engine, while routing the active engine's pixels to the VGA port.
// The scroll offset is latched once per frame, so it stays stable while the frame is drawn.
// Ports:
//   clock  - sole clock, rising edge
//   reset  - synchronous, active-high
//   bus    - draw_scheduler_if.slave (controls, engine handshakes/pixels, VGA port, status)
module draw_scheduler #(
    parameter int unsigned COLOR_DEPTH = 9,
    parameter int unsigned OFFSET_W    = 11,
    parameter int unsigned MAX_OFFSET  = 1980
) (
    input logic              clock,
    input logic              reset,
    draw_scheduler_if.slave  bus
);
    typedef enum logic [2:0] {
        StIdle, StLatch, StBgArm, StBgWait, StSprArm, StSprWait, StFrameEnd
    } state_e;

    // One extra bit so that decrementing 0 shows up as a set MSB instead of wrapping.
    localparam logic [OFFSET_W:0] MaxOffset = (OFFSET_W + 1)'(MAX_OFFSET);
    localparam logic [OFFSET_W:0] One       = (OFFSET_W + 1)'(1);

    state_e              state_q;
    logic [OFFSET_W:0]   pend_q, pend_d, pend_dec;
    logic [OFFSET_W-1:0] x_offset_q;
    logic [7:0]          overrun_q;
    logic                bg_en_q, spr_en_q, busy_q;

    // Pending scroll offset; opposing pulses in one cycle cancel.
    always_comb begin
        pend_d   = pend_q;
        pend_dec = pend_q - One;
        if (bus.scroll_right && !bus.scroll_left) begin
            if (pend_q < MaxOffset) pend_d = pend_q + One;
        end else if (bus.scroll_left && !bus.scroll_right) begin
            if (!pend_dec[OFFSET_W]) pend_d = pend_dec;
        end
    end

    // Enables and busy are registered alongside each state transition.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= StIdle;
            pend_q     <= '0;
            x_offset_q <= '0;
            overrun_q  <= '0;
            bg_en_q    <= 1'b0;
            spr_en_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            pend_q <= pend_d;
            // Ticks outside IDLE (FRAME_END included) are dropped, never queued.
            if (bus.frame_tick && (state_q != StIdle) && (overrun_q != 8'hFF)) begin
                overrun_q <= overrun_q + 8'd1;
            end
            unique case (state_q)
                StIdle: begin
                    if (bus.frame_tick) begin
                        state_q <= StLatch;
                        busy_q  <= 1'b1;
                    end
                end
                StLatch: begin
                    x_offset_q <= pend_q[OFFSET_W-1:0];
                    state_q    <= StBgArm;
                    bg_en_q    <= 1'b1;
                end
                StBgArm: begin
                    if (!bus.bg_done) begin
                        state_q <= StBgWait;
                        bg_en_q <= 1'b0;
                    end
                end
                StBgWait: begin
                    if (bus.bg_done) begin
                        if (bus.spr_phase_en) begin
                            state_q  <= StSprArm;
                            spr_en_q <= 1'b1;
                        end else begin
                            state_q <= StFrameEnd;
                        end
                    end
                end
                StSprArm: begin
                    if (!bus.spr_done) begin
                        state_q  <= StSprWait;
                        spr_en_q <= 1'b0;
                    end
                end
                StSprWait: begin
                    if (bus.spr_done) state_q <= StFrameEnd;
                end
                StFrameEnd: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q  <= StIdle;
                    bg_en_q  <= 1'b0;
                    spr_en_q <= 1'b0;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    // Pixel arbitration depends only on the state register.
    logic [7:0]             mux_x;
    logic [6:0]             mux_y;
    logic [COLOR_DEPTH-1:0] mux_color;
    logic                   mux_plot;

    always_comb begin
        mux_x     = '0;
        mux_y     = '0;
        mux_color = '0;
        mux_plot  = 1'b0;
        if (state_q == StBgArm || state_q == StBgWait) begin
            mux_x     = bus.bg_x;
            mux_y     = bus.bg_y;
            mux_color = bus.bg_color;
            mux_plot  = bus.bg_plot;
        end else if (state_q == StSprArm || state_q == StSprWait) begin
            mux_x     = bus.spr_x;
            mux_y     = bus.spr_y;
            mux_color = bus.spr_color;
            mux_plot  = bus.spr_plot;
        end
    end

    assign bus.vga_x         = mux_x;
    assign bus.vga_y         = mux_y;
    assign bus.vga_color     = mux_color;
    assign bus.vga_plot      = mux_plot;
    assign bus.bg_enable     = bg_en_q;
    assign bus.spr_enable    = spr_en_q;
    assign bus.busy          = busy_q;
    assign bus.x_offset      = x_offset_q;
    assign bus.overrun_count = overrun_q;
endmodule

// File: tb/tb_draw_scheduler.sv
// Testbench for draw_scheduler: engine models, a behavioural reference model, and scenario tasks.
module tb_draw_scheduler;
    localparam int unsigned CD   = 9;
    localparam int unsigned OW   = 11;
    localparam int          MAXO = 1980;
    localparam int M_IDLE = 0, M_LATCH = 1, M_BGA = 2, M_BGW = 3, M_SPRA = 4, M_SPRW = 5,
                   M_FE = 6;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    draw_scheduler_if #(.COLOR_DEPTH(CD), .OFFSET_W(OW)) bus_if ();

    draw_scheduler #(.COLOR_DEPTH(CD), .OFFSET_W(OW), .MAX_OFFSET(MAXO)) dut (
        .clock (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    int checks = 0;
    int errors = 0;
    logic force_spr_plot = 1'b0;

    // Engine models: done drops 2 cycles after enable is first seen, and rises 50 cycles later.
    int bg_cnt, spr_cnt;
    always @(posedge clk) begin
        if (reset) begin
            bus_if.bg_done <= 1'b1;
            bg_cnt <= 0;
        end else if (bg_cnt == 0) begin
            if (bus_if.bg_enable) bg_cnt <= 1;
        end else if (bg_cnt == 51) begin
            bus_if.bg_done <= 1'b1;
            bg_cnt <= 0;
        end else begin
            if (bg_cnt == 1) bus_if.bg_done <= 1'b0;
            bg_cnt <= bg_cnt + 1;
        end
    end
    always @(posedge clk) begin
        if (reset) begin
            bus_if.spr_done <= 1'b1;
            spr_cnt <= 0;
        end else if (spr_cnt == 0) begin
            if (bus_if.spr_enable) spr_cnt <= 1;
        end else if (spr_cnt == 51) begin
            bus_if.spr_done <= 1'b1;
            spr_cnt <= 0;
        end else begin
            if (spr_cnt == 1) bus_if.spr_done <= 1'b0;
            spr_cnt <= spr_cnt + 1;
        end
    end

    // Reference model: frame phase, integer scroll offset clamped to 0..MAXO, saturating drops.
    int m_phase, m_pend, m_xoff, m_ovr;

    function automatic int clampo(int v);
        return (v < 0) ? 0 : ((v > MAXO) ? MAXO : v);
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_phase <= M_IDLE;
            m_pend  <= 0;
            m_xoff  <= 0;
            m_ovr   <= 0;
        end else begin
            if (bus_if.frame_tick && m_phase != M_IDLE) m_ovr <= (m_ovr < 255) ? m_ovr + 1 : 255;
            m_pend <= clampo(m_pend + int'(bus_if.scroll_right) - int'(bus_if.scroll_left));
            case (m_phase)
                M_IDLE:  if (bus_if.frame_tick) m_phase <= M_LATCH;
                M_LATCH: begin m_xoff <= m_pend; m_phase <= M_BGA; end
                M_BGA:   if (!bus_if.bg_done) m_phase <= M_BGW;
                M_BGW:   if (bus_if.bg_done) m_phase <= bus_if.spr_phase_en ? M_SPRA : M_FE;
                M_SPRA:  if (!bus_if.spr_done) m_phase <= M_SPRW;
                M_SPRW:  if (bus_if.spr_done) m_phase <= M_FE;
                default: m_phase <= M_IDLE;
            endcase
        end
    end

    logic [46:0] obs;
    assign obs = {bus_if.busy, bus_if.bg_enable, bus_if.spr_enable, bus_if.x_offset,
                  bus_if.overrun_count, bus_if.vga_plot, bus_if.vga_x, bus_if.vga_y,
                  bus_if.vga_color};

    function automatic logic [46:0] exp_vec();
        logic [7:0]    x;
        logic [6:0]    y;
        logic [CD-1:0] c;
        logic          p;
        x = '0; y = '0; c = '0; p = 1'b0;
        if (m_phase == M_BGA || m_phase == M_BGW) begin
            x = bus_if.bg_x; y = bus_if.bg_y; c = bus_if.bg_color; p = bus_if.bg_plot;
        end else if (m_phase == M_SPRA || m_phase == M_SPRW) begin
            x = bus_if.spr_x; y = bus_if.spr_y; c = bus_if.spr_color; p = bus_if.spr_plot;
        end
        return {m_phase != M_IDLE, m_phase == M_BGA, m_phase == M_SPRA, OW'(m_xoff),
                8'(m_ovr), p, x, y, c};
    endfunction

    // Drive one cycle of pulses plus fresh random pixels; returns at the following negedge.
    task automatic step(input logic t, input logic l, input logic r);
        bus_if.frame_tick   = t;
        bus_if.scroll_left  = l;
        bus_if.scroll_right = r;
        bus_if.bg_x      = 8'($urandom);
        bus_if.bg_y      = 7'($urandom);
        bus_if.bg_color  = CD'($urandom);
        bus_if.bg_plot   = 1'($urandom);
        bus_if.spr_x     = 8'($urandom);
        bus_if.spr_y     = 7'($urandom);
        bus_if.spr_color = CD'($urandom);
        bus_if.spr_plot  = force_spr_plot ? 1'b1 : 1'($urandom);
        @(posedge clk);
        @(negedge clk);
        bus_if.frame_tick   = 1'b0;
        bus_if.scroll_left  = 1'b0;
        bus_if.scroll_right = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        reset = 1'b0;
    endtask

    // Start a frame and follow it to IDLE, comparing every cycle.
    task automatic run_frame(input string name, output int busy_cyc, output int spr_seen);
        bit fin;
        fin = 0;
        busy_cyc = 0;
        spr_seen = 0;
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 300; i++) begin
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL %s cyc %0d: got %h want %h", name, i, obs, exp_vec());
            end
            if (bus_if.busy) busy_cyc++;
            if (bus_if.spr_enable) spr_seen++;
            if (m_phase == M_IDLE) begin
                fin = 1;
                break;
            end
            step(1'b0, 1'b0, 1'b0);
        end
        checks++;
        if (!fin) begin
            errors++;
            $display("FAIL %s timeout: frame still running, want back in idle", name);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        checks++;
        if (obs !== 47'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h want 0", obs);
        end
        reset = 1'b0;
        step(1'b0, 1'b0, 1'b0);
        checks++;
        if (obs !== 47'd0) begin
            errors++;
            $display("FAIL reset_priority: got %h want 0", obs);
        end
    endtask

    task automatic test_frame_seq();
        int bc, ss;
        do_reset();
        bus_if.spr_phase_en = 1'b1;
        run_frame("frame_seq", bc, ss);
        checks++;
        if (bc != 108) begin
            errors++;
            $display("FAIL frame_busy_cycles: got %0d want 108", bc);
        end
        checks++;
        if (ss != 3) begin
            errors++;
            $display("FAIL frame_spr_enable_cycles: got %0d want 3", ss);
        end
    endtask

    task automatic test_clamp();
        int bc, ss;
        do_reset();
        bus_if.spr_phase_en = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0);
        run_frame("clamp_low", bc, ss);
        checks++;
        if (bus_if.x_offset !== 11'd0) begin
            errors++;
            $display("FAIL clamp_low: got %0d want 0", bus_if.x_offset);
        end
        for (int i = 0; i < 1985; i++) begin
            step(1'b0, 1'b0, 1'b1);
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL scroll_right %0d: got %h want %h", i, obs, exp_vec());
            end
        end
        run_frame("clamp_high", bc, ss);
        checks++;
        if (bus_if.x_offset !== 11'd1980) begin
            errors++;
            $display("FAIL clamp_high: got %0d want 1980", bus_if.x_offset);
        end
    endtask

    task automatic test_cancel();
        int bc, ss;
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1);
        run_frame("cancel_pre", bc, ss);
        step(1'b0, 1'b1, 1'b1);
        run_frame("cancel", bc, ss);
        checks++;
        if (bus_if.x_offset !== 11'd5) begin
            errors++;
            $display("FAIL cancel: got %0d want 5", bus_if.x_offset);
        end
    endtask

    task automatic test_overrun();
        do_reset();
        bus_if.spr_phase_en = 1'b1;
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 20 && m_phase != M_BGW; i++) step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        checks++;
        if (bus_if.overrun_count !== 8'd1 || bus_if.busy !== 1'b1) begin
            errors++;
            $display("FAIL overrun_one: got count %0d busy %b want 1 busy 1",
                     bus_if.overrun_count, bus_if.busy);
        end
        for (int i = 0; i < 400; i++) begin
            step(1'b1, 1'b0, 1'b0);
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL overrun_run %0d: got %h want %h", i, obs, exp_vec());
            end
        end
        checks++;
        if (bus_if.overrun_count !== 8'd255) begin
            errors++;
            $display("FAIL overrun_saturate: got %0d want 255", bus_if.overrun_count);
        end
    endtask

    task automatic test_no_sprite();
        int bc, ss;
        do_reset();
        bus_if.spr_phase_en = 1'b0;
        force_spr_plot = 1'b1;
        run_frame("no_sprite", bc, ss);
        checks++;
        if (ss != 0 || bc != 55) begin
            errors++;
            $display("FAIL no_sprite: got spr_en %0d busy %0d want 0 and 55", ss, bc);
        end
        force_spr_plot = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus_if.spr_phase_en = 1'b1;
        force_spr_plot = 1'b1;
        for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 200 && m_phase != M_SPRW; i++) step(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0);
        checks++;
        if (bus_if.x_offset !== 11'd7 || bus_if.vga_plot !== 1'b1) begin
            errors++;
            $display("FAIL mid_frame_pre: got x_offset %0d plot %b want 7 and 1",
                     bus_if.x_offset, bus_if.vga_plot);
        end
        reset = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        checks++;
        if (bus_if.busy !== 1'b0 || bus_if.spr_enable !== 1'b0 || bus_if.vga_plot !== 1'b0 ||
            bus_if.x_offset !== 11'd0) begin
            errors++;
            $display("FAIL mid_frame_reset: got busy %b spr_en %b plot %b x_offset %0d want 0s",
                     bus_if.busy, bus_if.spr_enable, bus_if.vga_plot, bus_if.x_offset);
        end
        force_spr_plot = 1'b0;
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) == 0) bus_if.spr_phase_en = 1'($urandom);
            step($urandom_range(0, 59) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 2) == 0);
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL random %0d: got %h want %h", i, obs, exp_vec());
            end
        end
    endtask

    initial begin
        bus_if.frame_tick   = 1'b0;
        bus_if.scroll_left  = 1'b0;
        bus_if.scroll_right = 1'b0;
        bus_if.spr_phase_en = 1'b0;
        @(negedge clk);
        test_reset();
        test_frame_seq();
        test_clamp();
        test_cancel();
        test_overrun();
        test_no_sprite();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/draw_scheduler.md
DRAW_SCHEDULER -- requirements
Module: draw_scheduler

Interface
REQ-001 SHALL have parameter COLOR_DEPTH, default 9, pixel color width.
REQ-002 SHALL have parameter OFFSET_W, default 11, scroll offset width.
REQ-003 SHALL have parameter MAX_OFFSET, default 1980, largest legal x_offset (tilemap length 2000 minus 20 screen tiles).
REQ-004 SHALL have port clock  in  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port frame_tick  in  1  one-cycle pulse requesting a new frame redraw.
REQ-007 SHALL have port scroll_left / scroll_right  in  1 each  one-cycle scroll request pulses.
REQ-008 SHALL have port spr_phase_en  in  1  when 1, the sprite phase runs after the background phase.
REQ-009 SHALL have port bg_done / spr_done  in  1 each  engine idle flags (high when idle, low while busy).
REQ-010 SHALL have ports bg_x / spr_x in 8, bg_y / spr_y in 7, bg_color / spr_color in COLOR_DEPTH, bg_plot / spr_plot in 1: engine pixel outputs.
REQ-011 SHALL have port bg_enable / spr_enable  out  1 each  engine start requests.
REQ-012 SHALL have port x_offset  out  OFFSET_W  scroll offset presented to the background engine.
REQ-013 SHALL have ports vga_x out 8, vga_y out 7, vga_color out COLOR_DEPTH, vga_plot out 1: arbitrated pixel write port.
REQ-014 SHALL have port busy  out  1  high in every state except IDLE.
REQ-015 SHALL have port overrun_count  out  8  saturating count of dropped frame_ticks.

Function
REQ-016 SHALL implement states IDLE, LATCH, BG_ARM, BG_WAIT, SPR_ARM, SPR_WAIT, FRAME_END, held in a registered state vector.
REQ-017 IDLE -> LATCH on frame_tick; otherwise remain in IDLE.
REQ-018 LATCH SHALL copy pending_offset into x_offset, then go to BG_ARM; lasts exactly 1 cycle.
REQ-019 BG_ARM SHALL drive bg_enable=1 and remain in BG_ARM until bg_done==0 is sampled, then go to BG_WAIT.
REQ-020 BG_WAIT SHALL drive bg_enable=0 and leave when bg_done==1: to SPR_ARM if spr_phase_en==1, else to FRAME_END; spr_phase_en is sampled on that exit cycle.
REQ-021 SPR_ARM and SPR_WAIT SHALL mirror BG_ARM and BG_WAIT using spr_enable and spr_done; SPR_WAIT exits to FRAME_END.
REQ-022 FRAME_END SHALL last 1 cycle, then go to IDLE.
REQ-023 The pixel mux SHALL be a combinational function of the state register: in BG_ARM and BG_WAIT, vga_* = bg_*; in SPR_ARM and SPR_WAIT, vga_* = spr_*; in all other states vga_plot=0 and vga_x, vga_y, vga_color=0.
REQ-024 x_offset SHALL change only in LATCH and SHALL stay stable for the whole frame.
REQ-025 pending_offset SHALL be +1 on scroll_right and -1 on scroll_left, clamped to the range 0..MAX_OFFSET.
REQ-026 When scroll_left and scroll_right arrive in the same cycle, they SHALL cancel (no change).
REQ-027 Scroll pulses SHALL be accepted in every state; updates made during a frame take effect at the next LATCH.
REQ-028 A frame_tick in any state other than IDLE SHALL be dropped and SHALL increment overrun_count, saturating at 255.
REQ-029 A frame_tick sampled in FRAME_END SHALL also count as an overrun; the scheduler SHALL NOT queue ticks.
REQ-030 The width of pending_offset arithmetic SHALL be OFFSET_W+1, so that the decrement at 0 detects underflow without wrapping.

Reset
REQ-031 Reset SHALL force state=IDLE, pending_offset=0, x_offset=0 and overrun_count=0.
REQ-032 With the state in IDLE after reset, every output is 0: bg_enable, spr_enable, vga_plot, vga_x, vga_y, vga_color and busy.
REQ-033 Reset asserted mid-frame SHALL abandon the frame: enables drop on the next edge, and no stale plot is forwarded.
REQ-034 Reset SHALL take priority over frame_tick and over scroll pulses in the same cycle.

Verification
REQ-035 Reset, then frame_tick with spr_phase_en=1; engine models deassert done 2 cycles after enable and reassert it 50 cycles later -> sequence IDLE, LATCH, BG_ARM, BG_WAIT, SPR_ARM, SPR_WAIT, FRAME_END, IDLE; busy high throughout; vga_plot mirrors bg_plot and then spr_plot.
REQ-036 Clamp at both ends: 3 scroll_left pulses from reset -> x_offset=0 at next frame; 1985 scroll_right pulses -> x_offset=1980.
REQ-037 Simultaneous scroll_left and scroll_right at pending_offset=5 -> x_offset=5 after the next LATCH.
REQ-038 Drop and saturate: frame_tick during BG_WAIT -> tick ignored, overrun_count=1; 300 ticks while busy -> overrun_count=255.
REQ-039 spr_phase_en=0 -> BG_WAIT goes directly to FRAME_END; spr_enable never asserts; spr_plot=1 injected throughout never reaches vga_plot.
REQ-040 Reset asserted while in SPR_WAIT -> next cycle state=IDLE, spr_enable=0, vga_plot=0, and x_offset=0.
